// File: rtl/rv_rf_pkg.sv
// Shared defaults and index type for the rv multi-port integer register file.
package rv_rf_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int NRD_MAX  = 4;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rv_rf_mp_if.sv
// Read, write-back and issue/flush bus of the multi-port register file.
// The master side is decode plus write-back; the slave side is the register file.
interface rv_rf_mp_if
  import rv_rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]      rd_en_i;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;

  logic                wr0_en_i;
  logic [AW-1:0]       wr0_addr_i;
  logic [XLEN-1:0]     wr0_data_i;
  logic                wr1_en_i;
  logic [AW-1:0]       wr1_addr_i;
  logic [XLEN-1:0]     wr1_data_i;

  logic                issue_en_i;
  logic [AW-1:0]       issue_rd_i;
  logic                flush_i;

  modport master (
    output rd_en_i, rd_addr_i,
    output wr0_en_i, wr0_addr_i, wr0_data_i,
    output wr1_en_i, wr1_addr_i, wr1_data_i,
    output issue_en_i, issue_rd_i, flush_i,
    input  rd_data_o, rd_busy_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i,
    input  wr0_en_i, wr0_addr_i, wr0_data_i,
    input  wr1_en_i, wr1_addr_i, wr1_data_i,
    input  issue_en_i, issue_rd_i, flush_i,
    output rd_data_o, rd_busy_o
  );

endinterface

// File: rtl/rv_rf_scoreboard.sv
// Busy scoreboard: one pending-write flag per register with flush > issue > write-clear
// priority, plus a combinational lookup of the current (pre-edge) busy state.
module rv_rf_scoreboard
  import rv_rf_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              issue_en_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              wr0_en_i,
  input  logic [AW-1:0]     wr0_addr_i,
  input  logic              wr1_en_i,
  input  logic [AW-1:0]     wr1_addr_i,
  input  logic [NRD*AW-1:0] look_addr_i,
  output logic [NRD-1:0]    look_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // x0 never becomes busy: the loop starts at 1, which also drops issues to x0.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (issue_en_i && issue_rd_i == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((wr0_en_i && wr0_addr_i == AW'(r)) ||
                   (wr1_en_i && wr1_addr_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    look_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      look_busy_o[k] = busy_q[look_addr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/rv_rf_mp.sv
// Multi-port integer register file: NRD registered read ports, two prioritised write ports,
// hardwired x0 and busy scoreboard. Define RV_RF_BYPASS_EN for same-edge write-to-read bypass.
module rv_rf_mp
  import rv_rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
) (
  input logic         clk,
  input logic         rstn,
  rv_rf_mp_if.slave   rf
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [XLEN-1:0]     regs_q [NREG];
  logic                wr0_ok, wr1_ok;
  logic [NRD-1:0]      look_busy;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;
  logic [AW-1:0]       ra;

  // Port 1 loses to port 0 on an address collision; writes to x0 are dropped.
  assign wr0_ok = rf.wr0_en_i && (rf.wr0_addr_i != ZERO_IDX);
  assign wr1_ok = rf.wr1_en_i && (rf.wr1_addr_i != ZERO_IDX) &&
                  !(wr0_ok && (rf.wr1_addr_i == rf.wr0_addr_i));

  // NOTE: the array is reset because architectural state must read as zero after rstn;
  // this rules out mapping it onto a RAM macro without a separate clearing sequence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wr1_ok) regs_q[rf.wr1_addr_i] <= rf.wr1_data_i;
      if (wr0_ok) regs_q[rf.wr0_addr_i] <= rf.wr0_data_i;
    end
  end

  rv_rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (rf.flush_i),
    .issue_en_i  (rf.issue_en_i),
    .issue_rd_i  (rf.issue_rd_i),
    .wr0_en_i    (rf.wr0_en_i),
    .wr0_addr_i  (rf.wr0_addr_i),
    .wr1_en_i    (rf.wr1_en_i),
    .wr1_addr_i  (rf.wr1_addr_i),
    .look_addr_i (rf.rd_addr_i),
    .look_busy_o (look_busy)
  );

  // NOTE: combinational next-state uses blocking '=' with the hold value assigned first,
  // so no latch is inferred; the registers below take it with non-blocking '<='.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rf.rd_addr_i[k*AW +: AW];
      if (rf.rd_en_i[k]) begin
        rd_data_d[k*XLEN +: XLEN] = (ra == ZERO_IDX) ? '0 : regs_q[ra];
        rd_busy_d[k]              = look_busy[k];
`ifdef RV_RF_BYPASS_EN
        // A bypassed value is only busy if a new producer issues to it this same cycle.
        if (wr0_ok && (rf.wr0_addr_i == ra)) begin
          rd_data_d[k*XLEN +: XLEN] = rf.wr0_data_i;
          rd_busy_d[k] = rf.issue_en_i && !rf.flush_i && (rf.issue_rd_i == ra);
        end else if (wr1_ok && (rf.wr1_addr_i == ra)) begin
          rd_data_d[k*XLEN +: XLEN] = rf.wr1_data_i;
          rd_busy_d[k] = rf.issue_en_i && !rf.flush_i && (rf.issue_rd_i == ra);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rf.rd_data_o = rd_data_q;
  assign rf.rd_busy_o = rd_busy_q;

endmodule
